reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-side front end for the 32x32 register file. It merges results from the single-cycle ALU path and the multi-cycle slow path (loads, mul/div) into the register file's single write port, one write per cycle. Slow-path results wait in a small FIFO, and ALU results have priority with a bounded starvation guard. The block also flags pending writes against the two decode read addresses so decode can stall. It sits between the execute/memory stages and the register file write port.

## Interface
- DEPTH, 4: slow-path FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 3: consecutive blocked cycles before the FIFO head is forced through (≥1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- slow_valid  in  1  slow-path result present
- slow_ready  out  1  slow-path result accepted when slow_valid=1
- slow_addr  in  5  slow-path destination register
- slow_data  in  32  slow-path result
- rd_addr1, rd_addr2  in  5 each  decode read addresses
- pend_hit1, pend_hit2  out  1 each  a queued FIFO entry targets rd_addr1 / rd_addr2
- wb_write  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  32  register-file write data
- fifo_count  out  log2(DEPTH)+1  queued entries

## Operation
- Handshakes: transfer on valid&&ready at the rising edge. Inputs must hold while valid&&!ready.
- slow_ready = (fifo_count != DEPTH). Pushing is not allowed while full, even if a pop happens in the same cycle.
- x0 rule: an accepted write with addr==0 is consumed and discarded. It is never enqueued, never issued, and never counts as blocking.
- Per-cycle selection, in priority order:
  - FORCE: starve_cnt==STARVE_LIMIT and FIFO non-empty. alu_ready=0 and the FIFO head is issued.
  - ALU: alu_valid && alu_addr!=0 and not FORCE. The ALU write is issued. If the FIFO is non-empty, starve_cnt increments.
  - DRAIN: otherwise, if the FIFO is non-empty, the head is popped and issued.
  - IDLE: no write.
- alu_ready=1 in every case except FORCE.
- starve_cnt clears on any pop and whenever the FIFO is empty. It saturates at STARVE_LIMIT.
- Push and pop in the same cycle leave fifo_count unchanged. The pushed entry goes behind the head.
- An empty FIFO with a simultaneous slow push does not bypass. The entry is queued and drains at the earliest the next cycle.
- Order: FIFO entries issue in arrival order. No ordering exists between the ALU and slow paths. Upstream hazard logic uses pend_hit to prevent WAW conflicts.
- pend_hit1/pend_hit2 (combinational): 1 iff rd_addrN!=0 and any valid FIFO entry has addr==rd_addrN. Entries already moved to the wb_* register do not count.
- Width rules: addresses are 5 bits and data is 32 bits, passed through unmodified. fifo_count ranges 0..DEPTH. Read/write pointers wrap modulo DEPTH.

## Timing
- wb_write, wb_addr, wb_data are registered. An issue decided in cycle N appears on the wb_* outputs during cycle N+1, which gives 1-cycle latency.
- In IDLE, wb_write=0 and wb_addr/wb_data hold their last values.
- alu_ready, slow_ready and pend_hit* are combinational from current state and inputs.
- Reset (async assert, sync release) values:
  - wb_write=0, wb_addr=0, wb_data=0
  - fifo_count=0, starve_cnt=0, pointers=0
  - slow_ready=1, alu_ready=1, pend_hit*=0
- Reset asserted mid-operation discards all queued entries immediately. No write issues while rst_n=0.
- Throughput: one register-file write per cycle maximum. Worst-case FIFO head wait is STARVE_LIMIT+1 cycles.

## Test plan
- Reset/idle: rst_n low then high, no valids. Required: wb_write=0, fifo_count=0, slow_ready=1, alu_ready=1.
- ALU only: alu write r5=0x12345678 at cycle N. Required: wb_write=1, wb_addr=5, wb_data=0x12345678 in cycle N+1. The same write with addr 0 produces wb_write=0.
- FIFO fill and drain: 4 slow pushes r1..r4 (data 0xA1..0xA4) while ALU is continuously valid to r9.
  - slow_ready=0 after the 4th push.
  - FORCE happens after 3 blocked cycles: alu_ready=0 for one cycle and r1/0xA1 is issued.
  - Once the ALU goes idle, r2, r3, r4 drain in order on consecutive cycles.
- pend_hit: queue r7 while rd_addr1=7 and rd_addr2=0. Required: pend_hit1=1, pend_hit2=0. pend_hit1 drops the cycle the r7 entry pops.
- Simultaneous push/pop at fifo_count=2: fifo_count stays 2 and order is preserved. With fifo_count=4 and a pop that cycle, slow_ready stays 0.
- Mid-operation reset: with 3 entries queued, pulse rst_n low asynchronously. Required: fifo_count=0 and wb_write=0 immediately, and no stale write after release.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU results with queued
// slow-path results, with ALU priority bounded by a starvation guard.
module reg_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [4:0]               alu_addr,
   input  logic [31:0]              alu_data,
   input  logic                     slow_valid,
   output logic                     slow_ready,
   input  logic [4:0]               slow_addr,
   input  logic [31:0]              slow_data,
   input  logic [4:0]               rd_addr1,
   input  logic [4:0]               rd_addr2,
   output logic                     pend_hit1,
   output logic                     pend_hit2,
   output logic                     wb_write,
   output logic [4:0]               wb_addr,
   output logic [31:0]              wb_data,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);
   localparam logic [SW-1:0] LIMIT_CNT = SW'(STARVE_LIMIT);

   logic [4:0]    addrMem_q [DEPTH];
   logic [31:0]   dataMem_q [DEPTH];
   logic [PW-1:0] rdPtr_q, wrPtr_q;
   logic [PW:0]   count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          wbWrite_q;
   logic [4:0]    wbAddr_q;
   logic [31:0]   wbData_q;

   logic          fifoEmpty, fifoFull, forceIssue, aluIssue, popFifo, pushFifo;
   logic [PW-1:0] idx;

   // The FIFO head issues whenever the ALU does not; a FORCE simply suppresses the ALU.
   always_comb begin
      fifoEmpty  = (count_q == '0);
      fifoFull   = (count_q == FULL_CNT);
      forceIssue = (starve_q == LIMIT_CNT) && !fifoEmpty;
      aluIssue   = alu_valid && (alu_addr != 5'd0) && !forceIssue;
      popFifo    = !fifoEmpty && !aluIssue;
      pushFifo   = slow_valid && !fifoFull && (slow_addr != 5'd0);
      count_d    = count_q + (PW + 1)'(pushFifo) - (PW + 1)'(popFifo);
      if (popFifo || fifoEmpty)
         starve_d = '0;
      else if (starve_q != LIMIT_CNT)
         starve_d = starve_q + SW'(1);
      else
         starve_d = starve_q;
   end

   // Only the occupied window [rdPtr, rdPtr+count) is compared against decode addresses.
   always_comb begin
      pend_hit1 = 1'b0;
      pend_hit2 = 1'b0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rdPtr_q + PW'(k);
         if ((PW + 1)'(k) < count_q) begin
            if (rd_addr1 != 5'd0 && addrMem_q[idx] == rd_addr1) pend_hit1 = 1'b1;
            if (rd_addr2 != 5'd0 && addrMem_q[idx] == rd_addr2) pend_hit2 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addrMem_q[i] <= '0;
            dataMem_q[i] <= '0;
         end
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         wbWrite_q <= 1'b0;
         wbAddr_q  <= '0;
         wbData_q  <= '0;
      end else begin
         if (pushFifo) begin
            addrMem_q[wrPtr_q] <= slow_addr;
            dataMem_q[wrPtr_q] <= slow_data;
            wrPtr_q            <= wrPtr_q + PW'(1);
         end
         if (popFifo) rdPtr_q <= rdPtr_q + PW'(1);
         count_q   <= count_d;
         starve_q  <= starve_d;
         wbWrite_q <= aluIssue || popFifo;
         if (aluIssue) begin
            wbAddr_q <= alu_addr;
            wbData_q <= alu_data;
         end else if (popFifo) begin
            wbAddr_q <= addrMem_q[rdPtr_q];
            wbData_q <= dataMem_q[rdPtr_q];
         end
      end
   end

   assign alu_ready  = !forceIssue;
   assign slow_ready = !fifoFull;
   assign fifo_count = count_q;
   assign wb_write   = wbWrite_q;
   assign wb_addr    = wbAddr_q;
   assign wb_data    = wbData_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_reg_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 3;

   logic        clk, rst_n;
   logic        alu_valid, alu_ready, slow_valid, slow_ready;
   logic [4:0]  alu_addr, slow_addr, rd_addr1, rd_addr2, wb_addr;
   logic [31:0] alu_data, slow_data, wb_data;
   logic        pend_hit1, pend_hit2, wb_write;
   logic [2:0]  fifo_count;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } entry_t;

   entry_t      mQ[$];
   int          mStarve;
   logic        mWbWrite;
   logic [4:0]  mWbAddr;
   logic [31:0] mWbData;
   bit          aluHold, slowHold;
   int          compared, mismatched;

   reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_addr(slow_addr), .slow_data(slow_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
      .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mStarve  = 0;
      mWbWrite = 1'b0;
      mWbAddr  = '0;
      mWbData  = '0;
      aluHold  = 1'b0;
      slowHold = 1'b0;
   endtask

   // One clock cycle: check the combinational view, advance the model, check the registered view.
   task automatic applyStimulus(input string tag);
      bit force_, aluGo, slowRdy, hit1, hit2;
      #1;
      force_  = (mStarve == LIMIT) && (mQ.size() != 0);
      slowRdy = (mQ.size() != DEPTH);
      hit1 = 1'b0;
      hit2 = 1'b0;
      foreach (mQ[i]) begin
         if (rd_addr1 != 0 && mQ[i].a == rd_addr1) hit1 = 1'b1;
         if (rd_addr2 != 0 && mQ[i].a == rd_addr2) hit2 = 1'b1;
      end
      checkOutput({tag, ".alu_ready"},  32'(alu_ready),  32'(!force_));
      checkOutput({tag, ".slow_ready"}, 32'(slow_ready), 32'(slowRdy));
      checkOutput({tag, ".pend_hit1"},  32'(pend_hit1),  32'(hit1));
      checkOutput({tag, ".pend_hit2"},  32'(pend_hit2),  32'(hit2));

      aluGo = alu_valid && (alu_addr != 0) && !force_;
      if (force_ || (!aluGo && mQ.size() != 0)) begin
         mWbWrite = 1'b1;
         mWbAddr  = mQ[0].a;
         mWbData  = mQ[0].d;
         void'(mQ.pop_front());
         mStarve  = 0;
      end else if (aluGo) begin
         mWbWrite = 1'b1;
         mWbAddr  = alu_addr;
         mWbData  = alu_data;
         if (mQ.size() != 0 && mStarve < LIMIT) mStarve++;
      end else begin
         mWbWrite = 1'b0;
      end
      if (slow_valid && slowRdy && slow_addr != 0) mQ.push_back('{a: slow_addr, d: slow_data});
      aluHold  = alu_valid && force_;
      slowHold = slow_valid && !slowRdy;

      @(posedge clk);
      #1;
      checkOutput({tag, ".wb_write"},   32'(wb_write),   32'(mWbWrite));
      checkOutput({tag, ".wb_addr"},    32'(wb_addr),    32'(mWbAddr));
      checkOutput({tag, ".wb_data"},    wb_data,         mWbData);
      checkOutput({tag, ".fifo_count"}, 32'(fifo_count), 32'(mQ.size()));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      alu_valid  = 1'b0; alu_addr  = '0; alu_data  = '0;
      slow_valid = 1'b0; slow_addr = '0; slow_data = '0;
      rd_addr1   = '0;   rd_addr2  = '0;
      modelReset();

      // Reset and idle
      #1;
      checkOutput("rst.wb_write",   32'(wb_write),   32'd0);
      checkOutput("rst.fifo_count", 32'(fifo_count), 32'd0);
      checkOutput("rst.slow_ready", 32'(slow_ready), 32'd1);
      checkOutput("rst.alu_ready",  32'(alu_ready),  32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus("idle");
      checkOutput("idle.wb_addr", 32'(wb_addr), 32'd0);
      checkOutput("idle.wb_data", wb_data,      32'd0);

      // ALU only, then the same write to x0
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678;
      applyStimulus("alu5");
      checkOutput("alu5.wb_write", 32'(wb_write), 32'd1);
      checkOutput("alu5.wb_addr",  32'(wb_addr),  32'd5);
      checkOutput("alu5.wb_data",  wb_data,       32'h1234_5678);
      alu_addr = 5'd0;
      applyStimulus("alu0");
      checkOutput("alu0.wb_write", 32'(wb_write), 32'd0);
      checkOutput("alu0.wb_addr",  32'(wb_addr),  32'd5);

      // Fill with ALU busy on r9, FORCE, then drain
      alu_addr = 5'd9; alu_data = 32'h99;
      for (int i = 1; i <= 4; i++) begin
         slow_valid = 1'b1; slow_addr = 5'(i); slow_data = 32'hA0 + 32'(i);
         applyStimulus("fill");
      end
      checkOutput("full.slow_ready", 32'(slow_ready), 32'd0);
      checkOutput("full.fifo_count", 32'(fifo_count), 32'd4);
      checkOutput("full.alu_ready",  32'(alu_ready),  32'd0);
      slow_addr = 5'd10; slow_data = 32'hAA;
      applyStimulus("force");
      checkOutput("force.wb_addr", 32'(wb_addr), 32'd1);
      checkOutput("force.wb_data", wb_data,      32'hA1);
      applyStimulus("afterforce");
      checkOutput("afterforce.wb_addr", 32'(wb_addr), 32'd9);
      alu_valid = 1'b0; slow_valid = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         applyStimulus("drain");
         checkOutput("drain.wb_addr", 32'(wb_addr), 32'(i));
      end
      applyStimulus("drain10");
      checkOutput("drain10.wb_data", wb_data, 32'hAA);

      // pend_hit on r7
      rd_addr1 = 5'd7; rd_addr2 = 5'd0;
      slow_valid = 1'b1; slow_addr = 5'd7; slow_data = 32'h77;
      applyStimulus("push7");
      checkOutput("push7.pend_hit1", 32'(pend_hit1), 32'd1);
      checkOutput("push7.pend_hit2", 32'(pend_hit2), 32'd0);
      slow_valid = 1'b0; alu_valid = 1'b1;
      applyStimulus("hold7");
      alu_valid = 1'b0;
      applyStimulus("pop7");
      checkOutput("pop7.pend_hit1", 32'(pend_hit1), 32'd0);
      checkOutput("pop7.wb_addr",   32'(wb_addr),   32'd7);

      // Simultaneous push and pop at two entries
      alu_valid = 1'b1; slow_valid = 1'b1;
      slow_addr = 5'd1; slow_data = 32'hB1; applyStimulus("pp1");
      slow_addr = 5'd2; slow_data = 32'hB2; applyStimulus("pp2");
      alu_valid = 1'b0;
      slow_addr = 5'd3; slow_data = 32'hB3; applyStimulus("pp3");
      checkOutput("pp3.fifo_count", 32'(fifo_count), 32'd2);
      checkOutput("pp3.wb_addr",    32'(wb_addr),    32'd1);
      slow_valid = 1'b0;
      applyStimulus("ppd2");
      checkOutput("ppd2.wb_data", wb_data, 32'hB2);
      applyStimulus("ppd3");
      checkOutput("ppd3.wb_data", wb_data, 32'hB3);

      // Mid-operation reset with three queued entries
      alu_valid = 1'b1; slow_valid = 1'b1;
      for (int i = 11; i <= 13; i++) begin
         slow_addr = 5'(i); slow_data = 32'(i);
         applyStimulus("q3");
      end
      slow_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("midrst.fifo_count", 32'(fifo_count), 32'd0);
      checkOutput("midrst.wb_write",   32'(wb_write),   32'd0);
      @(posedge clk);
      #1;
      checkOutput("inrst.wb_write", 32'(wb_write), 32'd0);
      rst_n = 1'b1; alu_valid = 1'b0;
      applyStimulus("postrst");
      checkOutput("postrst.wb_write", 32'(wb_write), 32'd0);

      // Random traffic honouring the hold-while-stalled rule
      for (int n = 0; n < 400; n++) begin
         if (!aluHold) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_addr  = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         if (!slowHold) begin
            slow_valid = ($urandom_range(0, 99) < 50);
            slow_addr  = 5'($urandom_range(0, 7));
            slow_data  = $urandom;
         end
         rd_addr1 = 5'($urandom_range(0, 7));
         rd_addr2 = 5'($urandom_range(0, 7));
         applyStimulus("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
